// File: rtl/mac_skew_feeder.sv
// Tile sequencer for the NxN systolic MAC array: holds one activation and one weight tile,
// then emits the diagonally skewed activation wavefront and loads one weight column per step.
module mac_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 2 * $clog2(N)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [N*DW-1:0]     act_out,
  output logic [N*N*DW-1:0]   w_out,
  output logic [23:0]         carry_in
);

  localparam int KW = $clog2(2 * N);
  localparam int HW = AW / 2;
  localparam logic [KW-1:0] K_LAST = KW'(2 * N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [N*DW-1:0]      act_q, act_d;
  logic [N*N*DW-1:0]    w_q, w_d;
  logic                 step_s;
  logic                 wr_ok_s;
  logic [HW-1:0]        wr_row_s, wr_col_s;
  logic [DW-1:0]        amem_q [N][N];
  logic [DW-1:0]        wmem_q [N][N];

  // Host writes land only while idle and not in the same cycle as a start.
  assign wr_ok_s  = wr_en & (state_q == S_IDLE) & ~start;
  assign wr_row_s = wr_addr[AW-1:HW];
  assign wr_col_s = wr_addr[HW-1:0];

  assign busy     = busy_q;
  assign done     = done_q;
  assign act_out  = act_q;
  assign w_out    = w_q;
  assign carry_in = 24'd0;

  // Next-state and next-step output computation.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    step_s  = 1'b0;
    act_d   = '0;
    w_d     = w_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
          busy_d  = 1'b1;
          step_s  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          k_d    = k_q + KW'(1);
          step_s = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
    // Row r sees amem[r][k-r]; column k of the weights is loaded while k < N.
    if (step_s) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          act_d[r*DW +: DW] = act_d[r*DW +: DW] |
                              ((int'(k_d) == r + c) ? amem_q[r][c] : '0);
          w_d[(r*N+c)*DW +: DW] = (int'(k_d) == c) ? wmem_q[r][c]
                                                   : w_q[(r*N+c)*DW +: DW];
        end
      end
    end else begin
      act_d = '0;
    end
  end

  // State, registered outputs and tile memories.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      act_q   <= '0;
      w_q     <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          amem_q[r][c] <= '0;
          wmem_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      act_q   <= act_d;
      w_q     <= w_d;
      if (wr_ok_s) begin
        if (wr_sel) begin
          wmem_q[wr_row_s][wr_col_s] <= wr_data;
        end else begin
          amem_q[wr_row_s][wr_col_s] <= wr_data;
        end
      end
    end
  end

endmodule
